// File: rtl/inet_csum_pkg.sv
// Shared types and helpers for the streaming Internet checksum engine.
package inet_csum_pkg;

   localparam int ACC_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      ACC,
      FOLD1,
      FOLD2,
      OUT
   } csum_state_e;

   // End-around carry: add the carry out of bit 15 back into the low word
   function automatic logic [15:0] fold16(input logic [16:0] s);
      return s[15:0] + {15'd0, s[16]};
   endfunction

endpackage

// File: rtl/csum_lane_adder.sv
// Beat sum: masks unkept bytes on the last beat, then adds the 16-bit words of one beat.
module csum_lane_adder #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]   data,
   input  logic [DATA_W/8-1:0] keep,
   input  logic                last,
   output logic [19:0]         beat_sum
);

   localparam int NB = DATA_W / 8;
   localparam int NW = DATA_W / 16;

   logic [DATA_W-1:0] masked;

   // Keep bit b guards byte lane b, so the MSB keep bit covers byte 0 in the MSBs
   always_comb begin
      masked = data;
      if (last) begin
         for (int b = 0; b < NB; b++) begin
            masked[8*b +: 8] = keep[b] ? data[8*b +: 8] : 8'h00;
         end
      end
   end

   always_comb begin
      beat_sum = '0;
      for (int w = 0; w < NW; w++) begin
         beat_sum = beat_sum + {4'd0, masked[16*w +: 16]};
      end
   end

endmodule

// File: rtl/inet_checksum_stream.sv
// Streaming RFC 1071 checksum over a valid/ready packet stream with a seeded start.
// Define INET_CSUM_VERIFY_EN to add the out_ok receive-side check output.
module inet_checksum_stream
   import inet_csum_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int ZERO_TO_FFFF = 0
) (
   input  logic                clk,
   input  logic                reset_p,
   input  logic [15:0]         in_seed,
   input  logic [DATA_W-1:0]   in_data,
   input  logic [DATA_W/8-1:0] in_keep,
   input  logic                in_valid,
   input  logic                in_last,
   output logic                in_ready,
   output logic [15:0]         out_csum,
   output logic                out_valid,
   input  logic                out_ready
`ifdef INET_CSUM_VERIFY_EN
   ,
   output logic                out_ok
`endif
);

   csum_state_e      state;
   logic [ACC_W-1:0] acc;
   logic [16:0]      s1;
   logic [15:0]      s2;

   logic [19:0]      beat_sum;
   logic             beat_xfer;
   logic [ACC_W-1:0] acc_first;
   logic [ACC_W-1:0] acc_more;
   logic [15:0]      s2_next;

   csum_lane_adder #(
      .DATA_W(DATA_W)
   ) u_lane_adder (
      .data     (in_data),
      .keep     (in_keep),
      .last     (in_last),
      .beat_sum (beat_sum)
   );

   // Refolding acc[31:16] into every beat keeps acc below 2^21 for any packet length
   assign beat_xfer = in_valid && in_ready;
   assign acc_first = {16'd0, in_seed} + {12'd0, beat_sum};
   assign acc_more  = {16'd0, acc[15:0]} + {16'd0, acc[31:16]} + {12'd0, beat_sum};
   assign s2_next   = fold16(s1);

   function automatic logic [15:0] final_csum(input logic [15:0] s);
      logic [15:0] c;
      c = ~s;
      if ((ZERO_TO_FFFF != 0) && (c == 16'h0000)) begin
         c = 16'hFFFF;
      end
      return c;
   endfunction

   // in_ready is registered so it is low throughout reset and rises one cycle after it
   always_ff @(posedge clk) begin
      if (reset_p) begin
         state     <= IDLE;
         acc       <= '0;
         s1        <= '0;
         s2        <= '0;
         out_csum  <= 16'h0000;
         out_valid <= 1'b0;
         in_ready  <= 1'b0;
`ifdef INET_CSUM_VERIFY_EN
         out_ok    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (beat_xfer) begin
                  acc <= acc_first;
                  if (in_last) begin
                     state    <= FOLD1;
                     in_ready <= 1'b0;
                  end else begin
                     state <= ACC;
                  end
               end
            end
            ACC: begin
               if (beat_xfer) begin
                  acc <= acc_more;
                  if (in_last) begin
                     state    <= FOLD1;
                     in_ready <= 1'b0;
                  end
               end
            end
            FOLD1: begin
               s1    <= {1'b0, acc[31:16]} + {1'b0, acc[15:0]};
               state <= FOLD2;
            end
            FOLD2: begin
               s2        <= s2_next;
               out_csum  <= final_csum(s2_next);
               out_valid <= 1'b1;
`ifdef INET_CSUM_VERIFY_EN
               out_ok    <= (s2_next == 16'hFFFF);
`endif
               state     <= OUT;
            end
            OUT: begin
               out_csum <= final_csum(s2);
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inet_checksum_stream.sv
// Self-checking bench: table-driven packets through a 32-bit engine with a scoreboard,
// plus 16-bit instances for the keep-mask and zero-mapping corner cases.
module tb_inet_checksum_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_p;

   logic [15:0] seed32;
   logic [31:0] data32;
   logic [3:0]  keep32;
   logic        valid32, last32, ready32;
   logic [15:0] csum32;
   logic        ovalid32, oready32;
`ifdef INET_CSUM_VERIFY_EN
   logic        ok32;
`endif

   inet_checksum_stream #(.DATA_W(32), .ZERO_TO_FFFF(0)) dut32 (
      .clk(clk), .reset_p(reset_p), .in_seed(seed32), .in_data(data32), .in_keep(keep32),
      .in_valid(valid32), .in_last(last32), .in_ready(ready32),
      .out_csum(csum32), .out_valid(ovalid32), .out_ready(oready32)
`ifdef INET_CSUM_VERIFY_EN
      , .out_ok(ok32)
`endif
   );

   logic [15:0] data16 [2];
   logic [1:0]  keep16 [2];
   logic        valid16 [2];
   logic        last16 [2];
   logic        ready16 [2];
   logic [15:0] csum16 [2];
   logic        ovalid16 [2];
`ifdef INET_CSUM_VERIFY_EN
   logic        ok16 [2];
`endif

   inet_checksum_stream #(.DATA_W(16), .ZERO_TO_FFFF(0)) dut16 (
      .clk(clk), .reset_p(reset_p), .in_seed(16'h0000), .in_data(data16[0]), .in_keep(keep16[0]),
      .in_valid(valid16[0]), .in_last(last16[0]), .in_ready(ready16[0]),
      .out_csum(csum16[0]), .out_valid(ovalid16[0]), .out_ready(1'b1)
`ifdef INET_CSUM_VERIFY_EN
      , .out_ok(ok16[0])
`endif
   );

   inet_checksum_stream #(.DATA_W(16), .ZERO_TO_FFFF(1)) dut16z (
      .clk(clk), .reset_p(reset_p), .in_seed(16'h0000), .in_data(data16[1]), .in_keep(keep16[1]),
      .in_valid(valid16[1]), .in_last(last16[1]), .in_ready(ready16[1]),
      .out_csum(csum16[1]), .out_valid(ovalid16[1]), .out_ready(1'b1)
`ifdef INET_CSUM_VERIFY_EN
      , .out_ok(ok16[1])
`endif
   );

   int checks = 0;
   int errors = 0;
   int pushed = 0;
   int outs_seen = 0;

   typedef struct packed {
      logic [15:0] csum;
      logic        ok;
   } exp_t;

   exp_t sbq[$];

   typedef struct {
      logic [15:0]       seed;
      int                nbeats;
      logic [7:0][31:0]  beats;
      logic [3:0]        keep;
      logic [15:0]       csum;
      logic              ok;
   } vec_t;

   localparam int NV = 9;
   vec_t vecs [NV];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [15:0] seed, input int n,
                               input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2,
                               input logic [31:0] b3, input logic [31:0] b4,
                               input logic [3:0] keep, input logic [15:0] csum, input logic ok);
      vec_t v;
      v.seed = seed;
      v.nbeats = n;
      v.beats = '0;
      v.beats[0] = b0;
      v.beats[1] = b1;
      v.beats[2] = b2;
      v.beats[3] = b3;
      v.beats[4] = b4;
      v.keep = keep;
      v.csum = csum;
      v.ok = ok;
      return v;
   endfunction

   // Scoreboard: an output handshake completes at the posedge after this negedge
   always @(negedge clk) begin
      exp_t e;
      if (!reset_p && ovalid32 && oready32) begin
         outs_seen++;
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL sb_unexpected: got output %h, expected none", csum32);
         end else begin
            e = sbq.pop_front();
            checkOutput("sb_csum", {16'd0, csum32}, {16'd0, e.csum});
`ifdef INET_CSUM_VERIFY_EN
            checkOutput("sb_ok", {31'd0, ok32}, {31'd0, e.ok});
`endif
         end
      end
   end

   task automatic applyStimulus(input logic [31:0] d, input logic [3:0] k, input logic l,
                                input logic [15:0] s, input exp_t e, input bit push);
      int waited;
      data32 = d;
      keep32 = k;
      last32 = l;
      seed32 = s;
      valid32 = 1'b1;
      waited = 0;
      @(negedge clk);
      while (!ready32 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!ready32) begin
         checks++;
         errors++;
         $display("[TB] FAIL beat_timeout: got in_ready 0, expected 1");
      end
      @(posedge clk);
      if (l && push && ready32) begin
         sbq.push_back(e);
         pushed++;
      end
      #1;
      valid32 = 1'b0;
      last32 = 1'b0;
   endtask

   task automatic send_vec(input vec_t v);
      exp_t e;
      e.csum = v.csum;
      e.ok = v.ok;
      for (int b = 0; b < v.nbeats; b++) begin
         applyStimulus(v.beats[b], (b == v.nbeats - 1) ? v.keep : 4'hF,
                       (b == v.nbeats - 1), v.seed, e, 1'b1);
      end
      checkOutput("lat_fold1", {31'd0, ovalid32}, 32'd0);
      @(posedge clk); #1;
      checkOutput("lat_fold2", {31'd0, ovalid32}, 32'd0);
      @(posedge clk); #1;
      checkOutput("lat_out", {31'd0, ovalid32}, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic run16(input int i, input logic [15:0] d, input logic [1:0] k,
                        input logic [15:0] exp, input logic expok);
      int n;
      data16[i] = d;
      keep16[i] = k;
      last16[i] = 1'b1;
      valid16[i] = 1'b1;
      n = 0;
      @(negedge clk);
      while (!ready16[i] && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk); #1;
      valid16[i] = 1'b0;
      n = 0;
      while (!ovalid16[i] && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput($sformatf("w16_%0d_valid", i), {31'd0, ovalid16[i]}, 32'd1);
      checkOutput($sformatf("w16_%0d_csum", i), {16'd0, csum16[i]}, {16'd0, exp});
`ifdef INET_CSUM_VERIFY_EN
      checkOutput($sformatf("w16_%0d_ok", i), {31'd0, ok16[i]}, {31'd0, expok});
`else
      if (expok === 1'bx) $display("[TB] note: unknown ok expectation");
`endif
      @(posedge clk); #1;
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: got no finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int seen_before;
      int n;
      exp_t e;

      vecs[0] = mk(16'h0000, 5, 32'h45000073, 32'h00004000, 32'h40110000, 32'hc0a80001, 32'hc0a800c7, 4'hF, 16'hB861, 1'b0);
      vecs[1] = mk(16'h1234, 5, 32'h45000073, 32'h00004000, 32'h40110000, 32'hc0a80001, 32'hc0a800c7, 4'hF, 16'hA62D, 1'b0);
      vecs[2] = mk(16'h0000, 1, 32'h11223344, 0, 0, 0, 0, 4'hC, 16'hEEDD, 1'b0);
      vecs[3] = mk(16'h0000, 2, 32'h00010002, 32'hFFFFFFFF, 0, 0, 0, 4'h0, 16'hFFFC, 1'b0);
      vecs[4] = mk(16'h0000, 1, 32'h01020304, 0, 0, 0, 0, 4'hE, 16'hFBFD, 1'b0);
      vecs[5] = mk(16'hFFFF, 2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 4'hF, 16'h0000, 1'b1);
      vecs[6] = mk(16'h8000, 1, 32'h80000000, 0, 0, 0, 0, 4'hF, 16'hFFFE, 1'b0);
      vecs[7] = mk(16'h0000, 5, 32'h45000073, 32'h00004000, 32'h4011b861, 32'hc0a80001, 32'hc0a800c7, 4'hF, 16'h0000, 1'b1);
      vecs[8] = mk(16'h0000, 5, 32'h45000074, 32'h00004000, 32'h4011b861, 32'hc0a80001, 32'hc0a800c7, 4'hF, 16'hFFFE, 1'b0);

      reset_p = 1'b1;
      seed32 = '0; data32 = '0; keep32 = '0; valid32 = 1'b0; last32 = 1'b0; oready32 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         data16[i] = '0; keep16[i] = '0; valid16[i] = 1'b0; last16[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_in_ready", {31'd0, ready32}, 32'd0);
      checkOutput("rst_out_valid", {31'd0, ovalid32}, 32'd0);
      checkOutput("rst_out_csum", {16'd0, csum32}, 32'd0);
`ifdef INET_CSUM_VERIFY_EN
      checkOutput("rst_out_ok", {31'd0, ok32}, 32'd0);
`endif
      reset_p = 1'b0;
      @(posedge clk); #1;
      checkOutput("post_rst_in_ready", {31'd0, ready32}, 32'd1);

      for (int i = 0; i < NV; i++) begin
         send_vec(vecs[i]);
      end

      // Output stall: result held while a second packet waits at the input
      oready32 = 1'b0;
      e.csum = 16'hEEDD; e.ok = 1'b0;
      applyStimulus(32'h11223344, 4'hC, 1'b1, 16'h0000, e, 1'b1);
      n = 0;
      while (!ovalid32 && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("stall_valid_rise", {31'd0, ovalid32}, 32'd1);
      data32 = 32'h01020304; keep32 = 4'hE; last32 = 1'b1; valid32 = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         checkOutput("stall_valid", {31'd0, ovalid32}, 32'd1);
         checkOutput("stall_csum", {16'd0, csum32}, 32'h0000EEDD);
         checkOutput("stall_in_ready", {31'd0, ready32}, 32'd0);
      end
      seen_before = outs_seen;
      oready32 = 1'b1;
      e.csum = 16'hFBFD; e.ok = 1'b0;
      applyStimulus(32'h01020304, 4'hE, 1'b1, 16'h0000, e, 1'b1);
      checkOutput("stall_order", outs_seen, seen_before + 1);
      repeat (4) @(posedge clk);
      #1;

      // Reset mid-stream after two beats, then a clean packet
      seen_before = outs_seen;
      applyStimulus(vecs[0].beats[0], 4'hF, 1'b0, 16'h0000, e, 1'b0);
      applyStimulus(vecs[0].beats[1], 4'hF, 1'b0, 16'h0000, e, 1'b0);
      reset_p = 1'b1;
      @(posedge clk); #1;
      checkOutput("midrst_in_ready", {31'd0, ready32}, 32'd0);
      checkOutput("midrst_out_valid", {31'd0, ovalid32}, 32'd0);
      @(posedge clk); #1;
      reset_p = 1'b0;
      @(posedge clk); #1;
      checkOutput("midrst_ready_rise", {31'd0, ready32}, 32'd1);
      send_vec(vecs[0]);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("midrst_one_output", outs_seen, seen_before + 1);

      // Reset during folding discards the packet
      seen_before = outs_seen;
      applyStimulus(32'h11223344, 4'hC, 1'b1, 16'h0000, e, 1'b0);
      reset_p = 1'b1;
      @(posedge clk); #1;
      reset_p = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      checkOutput("midfold_no_output", outs_seen, seen_before);
      send_vec(vecs[2]);

      run16(0, 16'hAB00, 2'b10, 16'h54FF, 1'b0);
      run16(0, 16'hFFFF, 2'b11, 16'h0000, 1'b1);
      run16(1, 16'hFFFF, 2'b11, 16'hFFFF, 1'b1);
      run16(1, 16'hAB00, 2'b10, 16'h54FF, 1'b0);

      repeat (5) @(posedge clk);
      #1;
      checkOutput("sb_empty", sbq.size(), 32'd0);
      checkOutput("outs_total", outs_seen, pushed);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
